// File: rtl/bpm_bright_pkg.sv
// Shared types and helpers for the BPM brightness pipe: blend modes,
// BPM input width, and the per-component blend function.
package bpm_bright_pkg;

    typedef enum logic [1:0] {
        MODE_BYPASS  = 2'd0,
        MODE_AVG     = 2'd1,
        MODE_SAT_ADD = 2'd2,
        MODE_SAT_SUB = 2'd3
    } mode_e;

    // Widest component the blend function supports; callers zero-extend.
    localparam int MAX_W       = 16;
    localparam int DEF_MAX_BPM = 200;

    function automatic int bpm_width(input int max_bpm);
        return $clog2(max_bpm + 1);
    endfunction

    localparam int BPM_W = bpm_width(DEF_MAX_BPM);

    // maxv is the all-ones value of the caller's component width.
    function automatic logic [MAX_W-1:0] blend_chan(
        input logic [MAX_W-1:0] p,
        input logic [MAX_W-1:0] b,
        input mode_e            mode,
        input logic [MAX_W-1:0] maxv
    );
        logic [MAX_W:0]   sum;
        logic [MAX_W-1:0] res;
        sum = {1'b0, p} + {1'b0, b};
        res = p;
        case (mode)
            MODE_AVG:     res = sum[MAX_W:1];
            MODE_SAT_ADD: res = (sum > {1'b0, maxv}) ? maxv : sum[MAX_W-1:0];
            MODE_SAT_SUB: res = (p > b) ? (p - b) : '0;
            default:      res = p;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/brightness_ramp.sv
// BPM-to-brightness target calculation with a per-frame slew limiter.
// Applied brightness moves only on frame_start, by at most MAX_STEP.
module brightness_ramp
    import bpm_bright_pkg::*;
#(
    parameter int BITS      = 8,
    parameter int MAX_BPM   = 200,
    parameter int STEP_SIZE = (256 * 256) / MAX_BPM,
    parameter int MAX_STEP  = 16,
    parameter int BPM_IN_W  = bpm_width(MAX_BPM)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [BPM_IN_W-1:0] bpm,
    input  logic                frame_start,
    output logic [BITS-1:0]     brightness,
    output logic                ramp_busy
);

    localparam int PROD_W = $clog2(STEP_SIZE * MAX_BPM + 1);
    localparam int CALC_W = (PROD_W > BITS + 1) ? PROD_W : BITS + 1;
    localparam int MAXV   = (1 << BITS) - 1;

    logic [BPM_IN_W-1:0] bpm_c;
    logic [CALC_W-1:0]   prod;
    logic [CALC_W-1:0]   scaled;
    logic [BITS-1:0]     target;
    logic [BITS-1:0]     up_gap;
    logic [BITS-1:0]     dn_gap;
    logic [BITS-1:0]     step_up;
    logic [BITS-1:0]     step_dn;

    assign bpm_c  = (bpm > BPM_IN_W'(MAX_BPM)) ? BPM_IN_W'(MAX_BPM) : bpm;
    // Product is sized for STEP_SIZE*MAX_BPM so nothing is lost before the clamp.
    assign prod   = CALC_W'(STEP_SIZE) * CALC_W'(bpm_c);
    assign scaled = prod >> 8;
    assign target = (scaled > CALC_W'(MAXV)) ? BITS'(MAXV) : scaled[BITS-1:0];

    assign up_gap  = target - brightness;
    assign dn_gap  = brightness - target;
    assign step_up = (up_gap > BITS'(MAX_STEP)) ? BITS'(MAX_STEP) : up_gap;
    assign step_dn = (dn_gap > BITS'(MAX_STEP)) ? BITS'(MAX_STEP) : dn_gap;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            brightness <= '0;
        end else if (frame_start) begin
            if (brightness < target) begin
                brightness <= brightness + step_up;
            end else if (brightness > target) begin
                brightness <= brightness - step_dn;
            end
        end
    end

    assign ramp_busy = (brightness != target);

endmodule

// File: rtl/bpm_brightness_pipe.sv
// Multi-channel pixel blend stage driven by slew-limited BPM brightness.
// One registered ready/valid stage; mode and enable are latched per frame.
module bpm_brightness_pipe
    import bpm_bright_pkg::*;
#(
    parameter int CHANNELS  = 3,
    parameter int BITS      = 8,
    parameter int MAX_BPM   = 200,
    parameter int STEP_SIZE = (256 * 256) / MAX_BPM,
    parameter int MAX_STEP  = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [CHANNELS*BITS-1:0]     s_pix,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic                         frame_start,
    input  logic                         filter_enable,
    input  logic [1:0]                   mode,
    input  logic [bpm_width(MAX_BPM)-1:0] bpm,
    output logic [CHANNELS*BITS-1:0]     m_pix,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [BITS-1:0]              brightness,
    output logic                         ramp_busy
);

    localparam int MAXV = (1 << BITS) - 1;

    mode_e                   mode_q;
    logic                    enable_q;
    mode_e                   mode_eff;
    logic                    accept;
    logic [CHANNELS*BITS-1:0] blended;

    brightness_ramp #(
        .BITS      (BITS),
        .MAX_BPM   (MAX_BPM),
        .STEP_SIZE (STEP_SIZE),
        .MAX_STEP  (MAX_STEP)
    ) u_ramp (
        .clk         (clk),
        .reset       (reset),
        .bpm         (bpm),
        .frame_start (frame_start),
        .brightness  (brightness),
        .ramp_busy   (ramp_busy)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q   <= MODE_BYPASS;
            enable_q <= 1'b0;
        end else if (frame_start) begin
            mode_q   <= mode_e'(mode);
            enable_q <= filter_enable;
        end
    end

    assign mode_eff = enable_q ? mode_q : MODE_BYPASS;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        assign blended[c*BITS +: BITS] = BITS'(blend_chan(
            MAX_W'(s_pix[c*BITS +: BITS]), MAX_W'(brightness), mode_eff, MAX_W'(MAXV)));
    end

    // Handshake: a beat moves when valid && ready; the output holds while stalled.
    assign s_ready = !m_valid || m_ready;
    assign accept  = s_valid && s_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_valid <= 1'b0;
            m_pix   <= '0;
        end else if (accept) begin
            m_valid <= 1'b1;
            m_pix   <= blended;
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bpm_brightness_pipe.sv
// Directed + randomized bench for bpm_brightness_pipe against an arithmetic
// reference model with an expected-output queue.
module tb_bpm_brightness_pipe;

    logic        clk;
    logic        reset;
    logic [23:0] s_pix;
    logic        s_valid;
    logic        s_ready;
    logic        frame_start;
    logic        filter_enable;
    logic [1:0]  mode;
    logic [7:0]  bpm;
    logic [23:0] m_pix;
    logic        m_valid;
    logic        m_ready;
    logic [7:0]  brightness;
    logic        ramp_busy;

    bpm_brightness_pipe dut (
        .clk           (clk),
        .reset         (reset),
        .s_pix         (s_pix),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .frame_start   (frame_start),
        .filter_enable (filter_enable),
        .mode          (mode),
        .bpm           (bpm),
        .m_pix         (m_pix),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .brightness    (brightness),
        .ramp_busy     (ramp_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          tx_cnt = 0;
    int          rx_cnt = 0;
    int          ref_b = 0;
    int          ref_mode = 0;
    int          ref_en = 0;
    bit          exp_valid = 1'b0;
    logic [23:0] exp_q[$];

    int up_tbl[8]   = '{16, 32, 48, 64, 80, 96, 112, 127};
    int md_tbl[5]   = '{1, 2, 3, 0, 1};
    int en_tbl[5]   = '{1, 1, 1, 1, 0};
    int lo_tbl[5]   = '{113, 227, 0, 100, 100};
    int hi_tbl[5]   = '{163, 255, 73, 200, 200};
    int rdy_pat[4]  = '{1, 0, 0, 1};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic int ref_target(input int b);
        int bc, t;
        bc = (b > 200) ? 200 : b;
        t  = (327 * bc) / 256;
        return (t > 255) ? 255 : t;
    endfunction

    function automatic int ref_blend(input int p, input int b, input int m);
        case (m)
            1:       return (p + b) / 2;
            2:       return (p + b > 255) ? 255 : p + b;
            3:       return (p > b) ? p - b : 0;
            default: return p;
        endcase
    endfunction

    function automatic logic [23:0] ref_pix(input logic [23:0] pix);
        logic [23:0] r;
        int          m;
        m = (ref_en != 0) ? ref_mode : 0;
        for (int c = 0; c < 3; c++) begin
            r[c*8 +: 8] = 8'(ref_blend(int'(pix[c*8 +: 8]), ref_b, m));
        end
        return r;
    endfunction

    task automatic model_reset();
        ref_b     = 0;
        ref_mode  = 0;
        ref_en    = 0;
        exp_valid = 1'b0;
        exp_q.delete();
    endtask

    // One clock: pre-edge checks at negedge, model update, post-edge checks.
    task automatic tick();
        bit acc, hs;
        int t;
        @(negedge clk);
        chk("s_ready", 32'(s_ready), 32'(!exp_valid || m_ready));
        hs  = exp_valid && m_ready;
        acc = s_valid && (!exp_valid || m_ready);
        if (hs && exp_q.size() > 0) begin
            chk("out_pix", 32'(m_pix), 32'(exp_q[0]));
            void'(exp_q.pop_front());
            rx_cnt++;
        end
        if (acc) begin
            exp_q.push_back(ref_pix(s_pix));
            tx_cnt++;
        end
        exp_valid = acc ? 1'b1 : (m_ready ? 1'b0 : exp_valid);
        if (frame_start) begin
            t = ref_target(int'(bpm));
            if (ref_b < t)      ref_b += (t - ref_b > 16) ? 16 : t - ref_b;
            else if (ref_b > t) ref_b -= (ref_b - t > 16) ? 16 : ref_b - t;
            ref_mode = int'(mode);
            ref_en   = int'(filter_enable);
        end
        @(posedge clk);
        #1;
        chk("m_valid", 32'(m_valid), 32'(exp_valid));
        chk("brightness", 32'(brightness), 32'(ref_b));
        chk("ramp_busy", 32'(ramp_busy), 32'(ref_b != ref_target(int'(bpm))));
        if (exp_valid && exp_q.size() > 0) chk("held_pix", 32'(m_pix), 32'(exp_q[0]));
    endtask

    task automatic pulse_frames(input int n);
        for (int k = 0; k < n; k++) begin
            frame_start = 1'b1;
            tick();
            frame_start = 1'b0;
            tick();
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        int cyc;
        reset         = 1'b1;
        s_pix         = '0;
        s_valid       = 1'b0;
        frame_start   = 1'b0;
        filter_enable = 1'b0;
        mode          = 2'd0;
        bpm           = 8'd0;
        m_ready       = 1'b1;
        #2;
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_pix", 32'(m_pix), 32'd0);
        chk("rst_brightness", 32'(brightness), 32'd0);
        chk("rst_ramp_busy", 32'(ramp_busy), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Ramp up to the bpm=100 target, with idle cycles between frames.
        bpm = 8'd100;
        for (int k = 0; k < 8; k++) begin
            frame_start = 1'b1;
            tick();
            frame_start = 1'b0;
            chk("ramp_up_step", 32'(brightness), 32'(up_tbl[k]));
            tick();
            tick();
            chk("ramp_hold", 32'(brightness), 32'(up_tbl[k]));
        end
        chk("ramp_done_busy", 32'(ramp_busy), 32'd0);

        // Clamped bpm, then ramp back down to zero.
        bpm = 8'd250;
        tick();
        chk("clamp_busy", 32'(ramp_busy), 32'd1);
        pulse_frames(9);
        chk("clamp_top", 32'(brightness), 32'd255);
        bpm = 8'd0;
        pulse_frames(15);
        chk("ramp_down_15", 32'(brightness), 32'd15);
        pulse_frames(1);
        chk("ramp_down_end", 32'(brightness), 32'd0);

        // Each mode at brightness 127 on components 100/200.
        bpm = 8'd100;
        pulse_frames(8);
        chk("b127", 32'(brightness), 32'd127);
        for (int i = 0; i < 5; i++) begin
            mode          = 2'(md_tbl[i]);
            filter_enable = 1'(en_tbl[i]);
            frame_start   = 1'b1;
            tick();
            frame_start = 1'b0;
            s_pix       = {8'($urandom_range(0, 255)), 8'd200, 8'd100};
            s_valid     = 1'b1;
            m_ready     = 1'b1;
            tick();
            s_valid = 1'b0;
            chk("mode_lo", 32'(m_pix[7:0]), 32'(lo_tbl[i]));
            chk("mode_hi", 32'(m_pix[15:8]), 32'(hi_tbl[i]));
            tick();
        end

        // Backpressure: 10 beats with m_ready cycling 1,0,0,1.
        mode          = 2'd1;
        filter_enable = 1'b1;
        frame_start   = 1'b1;
        tick();
        frame_start = 1'b0;
        begin
            int sent0;
            sent0 = tx_cnt;
            cyc   = 0;
            while (tx_cnt - sent0 < 10 && cyc < 80) begin
                s_valid = 1'b1;
                s_pix   = 24'($urandom);
                m_ready = 1'(rdy_pat[cyc % 4]);
                tick();
                cyc++;
            end
            chk("bp_sent", 32'(tx_cnt - sent0), 32'd10);
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        tick();
        tick();
        chk("bp_balance", 32'(tx_cnt - rx_cnt), 32'd0);

        // Random traffic with occasional frame boundaries and bpm changes.
        for (int i = 0; i < 300; i++) begin
            s_valid       = 1'($urandom_range(0, 1));
            m_ready       = ($urandom_range(0, 3) != 0);
            s_pix         = 24'($urandom);
            frame_start   = ($urandom_range(0, 7) == 0);
            mode          = 2'($urandom_range(0, 3));
            filter_enable = ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 15) == 0) bpm = 8'($urandom_range(0, 255));
            tick();
        end
        s_valid     = 1'b0;
        frame_start = 1'b0;
        m_ready     = 1'b1;
        tick();
        tick();
        chk("rand_balance", 32'(tx_cnt - rx_cnt), 32'd0);

        // frame_start on the same edge as an accepted beat.
        bpm = 8'd100;
        pulse_frames(10);
        chk("same_b127", 32'(brightness), 32'd127);
        mode          = 2'd1;
        filter_enable = 1'b1;
        frame_start   = 1'b1;
        tick();
        mode    = 2'd2;
        s_pix   = {8'd50, 8'd200, 8'd100};
        s_valid = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("same_avg_lo", 32'(m_pix[7:0]), 32'd113);
        chk("same_avg_hi", 32'(m_pix[15:8]), 32'd163);
        tick();
        s_valid = 1'b0;
        chk("next_add_lo", 32'(m_pix[7:0]), 32'd227);
        chk("next_add_hi", 32'(m_pix[15:8]), 32'd255);
        tick();

        // Reset while a beat is stalled and brightness is 64.
        do_reset();
        bpm = 8'd100;
        pulse_frames(4);
        chk("pre_rst_b64", 32'(brightness), 32'd64);
        s_pix   = 24'($urandom);
        s_valid = 1'b1;
        m_ready = 1'b0;
        tick();
        s_valid = 1'b0;
        chk("pre_rst_valid", 32'(m_valid), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_m_valid", 32'(m_valid), 32'd0);
        chk("async_m_pix", 32'(m_pix), 32'd0);
        chk("async_brightness", 32'(brightness), 32'd0);
        model_reset();
        #1;
        reset   = 1'b0;
        m_ready = 1'b1;
        tick();
        tick();
        pulse_frames(1);
        chk("restart_ramp", 32'(brightness), 32'd16);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
